// File: rtl/can_pkg.sv
// Shared CAN constants, parser state and field-select enums.
// Field widths also serve the transmit path.
package can_pkg;

  localparam int unsigned FRAME_W        = 150;
  localparam int unsigned STUFF_LEN      = 5;
  localparam int unsigned ID_STD_W       = 11;
  localparam int unsigned ID_EXT_W       = 18;
  localparam int unsigned ID_W           = ID_STD_W + ID_EXT_W;
  localparam int unsigned DLC_W          = 4;
  localparam int unsigned CRC_W          = 15;
  localparam int unsigned MAX_DATA_BYTES = 8;
  localparam int unsigned DATA_W         = 8 * MAX_DATA_BYTES;
  localparam int unsigned IDX_W          = $clog2(FRAME_W);
  localparam int unsigned CNT_W          = 7;
  localparam int unsigned RUN_W          = $clog2(STUFF_LEN + 1);
  localparam int unsigned DPTR_W         = $clog2(DATA_W);

  localparam logic [CRC_W-1:0] CRC_POLY = 15'h4599;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PARSE,
    ST_DONE
  } state_e;

  typedef enum logic [3:0] {
    F_SOF, F_ID_A, F_SRR_RTR, F_IDE, F_ID_B, F_RTR,
    F_R1, F_R0, F_DLC, F_DATA, F_CRC, F_CDEL
  } field_e;

endpackage

// File: rtl/can_crc15.sv
// Serial CAN CRC-15: one message bit per enabled clock, synchronous clear.
module can_crc15
  import can_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = CRC_POLY
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             bit_i,
  output logic [CRC_W-1:0] crc_o
);

  logic [CRC_W-1:0] crc_q, crc_d;
  logic             fb;

  always_comb begin
    fb    = bit_i ^ crc_q[CRC_W-1];
    crc_d = {crc_q[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     crc_q <= '0;
    else if (clr_i) crc_q <= '0;
    else if (en_i)  crc_q <= crc_d;
  end

  assign crc_o = crc_q;

endmodule

// File: rtl/can_frame_decoder.sv
// Walks a captured CAN frame one raw bit per clock: destuffs, extracts fields, checks CRC-15.
// Define CAN_EXT_ID_EN to decode 29-bit (IDE=1) frames; otherwise IDE=1 is a form error.
module can_frame_decoder
  import can_pkg::*;
(
  input  logic               baud_clk,
  input  logic               rst,
  input  logic [FRAME_W-1:0] shifted_bus,
  input  logic               finished_rx,
  output logic               busy,
  output logic               frame_done,
  output logic               frame_ok,
  output logic [ID_W-1:0]    rx_id,
  output logic               rx_ide,
  output logic               rx_rtr,
  output logic [DLC_W-1:0]   rx_dlc,
  output logic [DATA_W-1:0]  rx_data,
  output logic               err_stuff,
  output logic               err_crc,
  output logic               err_form,
  output logic               overrun
);

  state_e             state_q, state_d;
  field_e             field_q, field_d;
  logic [FRAME_W-1:0] buf_q, buf_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               last_q, last_d;
  logic [DPTR_W-1:0]  ptr_q, ptr_d;
  logic [CRC_W-2:0]   rxcrc_q, rxcrc_d;
  logic               fin_prev_q;

  logic               busy_q, busy_d, done_q, done_d, ok_q, ok_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic               ide_q, ide_d, rtr_q, rtr_d;
  logic [DLC_W-1:0]   dlc_q, dlc_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               es_q, es_d, ec_q, ec_d, ef_q, ef_d, ovr_q, ovr_d;

  logic               raw_bit, crc_clr, crc_en, finish;
  logic [ID_W-1:0]    id_shifted;
  logic [DLC_W-1:0]   dlc_full, n_bytes;
  logic [CRC_W-1:0]   crc_val;

  assign raw_bit  = buf_q[idx_q];
  assign dlc_full = {dlc_q[DLC_W-2:0], raw_bit};
  assign n_bytes  = rtr_q ? '0 : ((dlc_full > 4'd8) ? 4'd8 : dlc_full);

`ifdef CAN_EXT_ID_EN
  assign id_shifted = {id_q[ID_W-2:0], raw_bit};
`else
  assign id_shifted = {{ID_EXT_W{1'b0}}, id_q[ID_STD_W-2:0], raw_bit};
`endif

  can_crc15 u_crc (
    .clk   (baud_clk),
    .rst_n (rst),
    .clr_i (crc_clr),
    .en_i  (crc_en),
    .bit_i (raw_bit),
    .crc_o (crc_val)
  );

  always_comb begin
    state_d = state_q;  field_d = field_q;  buf_d  = buf_q;   idx_d   = idx_q;
    cnt_d   = cnt_q;    run_d   = run_q;    last_d = last_q;  ptr_d   = ptr_q;
    rxcrc_d = rxcrc_q;  busy_d  = busy_q;   done_d = 1'b0;    ok_d    = ok_q;
    id_d    = id_q;     ide_d   = ide_q;    rtr_d  = rtr_q;   dlc_d   = dlc_q;
    data_d  = data_q;   es_d    = es_q;     ec_d   = ec_q;    ef_d    = ef_q;
    ovr_d   = ovr_q;    crc_clr = 1'b0;     crc_en = 1'b0;    finish  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (finished_rx && !fin_prev_q) begin
          buf_d   = shifted_bus;
          idx_d   = IDX_W'(FRAME_W - 1);
          field_d = F_SOF;
          cnt_d   = '0;
          run_d   = '0;
          last_d  = 1'b0;
          ptr_d   = DPTR_W'(DATA_W - 1);
          busy_d  = 1'b1;
          ok_d    = 1'b0;
          id_d    = '0;  ide_d = 1'b0;  rtr_d = 1'b0;  dlc_d = '0;  data_d = '0;
          es_d    = 1'b0; ec_d = 1'b0;  ef_d  = 1'b0;  ovr_d = 1'b0;
          crc_clr = 1'b1;
          state_d = ST_PARSE;
        end
      end

      ST_PARSE: begin
        if (finished_rx) ovr_d = 1'b1;
        idx_d = IDX_W'(idx_q - 1'b1);
        // Bit after a full run is a stuff bit: dropped, never reaches CRC or fields.
        if (field_q != F_CDEL && run_q == RUN_W'(STUFF_LEN)) begin
          if (raw_bit == last_q) es_d = 1'b1;
          run_d  = RUN_W'(1);
          last_d = raw_bit;
        end else begin
          if (field_q != F_CDEL) begin
            run_d  = (run_q != '0 && raw_bit == last_q) ? RUN_W'(run_q + 1'b1) : RUN_W'(1);
            last_d = raw_bit;
          end
          crc_en = (field_q != F_CRC) && (field_q != F_CDEL);
          cnt_d  = CNT_W'(cnt_q - 1'b1);
          case (field_q)
            F_SOF: begin
              if (raw_bit) ef_d = 1'b1;
              field_d = F_ID_A;
              cnt_d   = CNT_W'(ID_STD_W - 1);
            end
            F_ID_A: begin
              id_d = id_shifted;
              if (cnt_q == '0) field_d = F_SRR_RTR;
            end
            F_SRR_RTR: begin
              rtr_d   = raw_bit;
              field_d = F_IDE;
            end
            F_IDE: begin
              ide_d = raw_bit;
              if (raw_bit) begin
`ifdef CAN_EXT_ID_EN
                if (!rtr_q) ef_d = 1'b1;
                field_d = F_ID_B;
                cnt_d   = CNT_W'(ID_EXT_W - 1);
`else
                ef_d   = 1'b1;
                finish = 1'b1;
`endif
              end else begin
                field_d = F_R0;
              end
            end
            F_ID_B: begin
              id_d = id_shifted;
              if (cnt_q == '0) field_d = F_RTR;
            end
            F_RTR: begin
              rtr_d   = raw_bit;
              field_d = F_R1;
            end
            F_R1: field_d = F_R0;
            F_R0: begin
              field_d = F_DLC;
              cnt_d   = CNT_W'(DLC_W - 1);
            end
            F_DLC: begin
              dlc_d = dlc_full;
              if (cnt_q == '0) begin
                if (n_bytes == '0) begin
                  field_d = F_CRC;
                  cnt_d   = CNT_W'(CRC_W - 1);
                end else begin
                  field_d = F_DATA;
                  cnt_d   = CNT_W'({n_bytes, 3'b000} - 7'd1);
                end
              end
            end
            F_DATA: begin
              data_d[ptr_q] = raw_bit;
              ptr_d         = DPTR_W'(ptr_q - 1'b1);
              if (cnt_q == '0) begin
                field_d = F_CRC;
                cnt_d   = CNT_W'(CRC_W - 1);
              end
            end
            F_CRC: begin
              rxcrc_d = {rxcrc_q[CRC_W-3:0], raw_bit};
              if (cnt_q == '0) begin
                field_d = F_CDEL;
                if ({rxcrc_q, raw_bit} != crc_val) ec_d = 1'b1;
              end
            end
            F_CDEL: begin
              if (!raw_bit) ef_d = 1'b1;
              finish = 1'b1;
            end
            default: ;
          endcase
        end
        // Buffer exhausted before the CRC delimiter: truncated frame.
        if (!finish && idx_q == '0) begin
          ef_d   = 1'b1;
          finish = 1'b1;
        end
        if (finish) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          ok_d    = !(es_d || ec_d || ef_d);
        end
      end

      ST_DONE: begin
        if (finished_rx) ovr_d = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge baud_clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;  field_q <= F_SOF;  buf_q  <= '1;  idx_q   <= '0;
      cnt_q   <= '0;       run_q   <= '0;     last_q <= 1'b0; ptr_q  <= '0;
      rxcrc_q <= '0;       fin_prev_q <= 1'b0;
      busy_q  <= 1'b0;     done_q  <= 1'b0;   ok_q   <= 1'b0;
      id_q    <= '0;       ide_q   <= 1'b0;   rtr_q  <= 1'b0; dlc_q  <= '0;
      data_q  <= '0;       es_q    <= 1'b0;   ec_q   <= 1'b0; ef_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;  field_q <= field_d;  buf_q  <= buf_d;   idx_q  <= idx_d;
      cnt_q   <= cnt_d;    run_q   <= run_d;    last_q <= last_d;  ptr_q  <= ptr_d;
      rxcrc_q <= rxcrc_d;  fin_prev_q <= finished_rx;
      busy_q  <= busy_d;   done_q  <= done_d;   ok_q   <= ok_d;
      id_q    <= id_d;     ide_q   <= ide_d;    rtr_q  <= rtr_d;   dlc_q  <= dlc_d;
      data_q  <= data_d;   es_q    <= es_d;     ec_q   <= ec_d;    ef_q   <= ef_d;
      ovr_q   <= ovr_d;
    end
  end

  assign busy       = busy_q;
  assign frame_done = done_q;
  assign frame_ok   = ok_q;
  assign rx_id      = id_q;
  assign rx_ide     = ide_q;
  assign rx_rtr     = rtr_q;
  assign rx_dlc     = dlc_q;
  assign rx_data    = data_q;
  assign err_stuff  = es_q;
  assign err_crc    = ec_q;
  assign err_form   = ef_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_can_frame_decoder.sv
// Bench for can_frame_decoder: encodes frames from field values (long-division CRC, bit stuffing)
// and checks the decoded outputs, timing and error flags.
module tb_can_frame_decoder;
  import can_pkg::*;

  logic               baud_clk = 1'b0;
  logic               rst;
  logic [FRAME_W-1:0] shifted_bus;
  logic               finished_rx;
  logic               busy, frame_done, frame_ok, rx_ide, rx_rtr;
  logic [ID_W-1:0]    rx_id;
  logic [DLC_W-1:0]   rx_dlc;
  logic [DATA_W-1:0]  rx_data;
  logic               err_stuff, err_crc, err_form, overrun;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  typedef struct packed {
    logic [28:0] id;
    logic        ext;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic [14:0] crc_xor;
  } frm_t;

  can_frame_decoder dut (
    .baud_clk    (baud_clk),
    .rst         (rst),
    .shifted_bus (shifted_bus),
    .finished_rx (finished_rx),
    .busy        (busy),
    .frame_done  (frame_done),
    .frame_ok    (frame_ok),
    .rx_id       (rx_id),
    .rx_ide      (rx_ide),
    .rx_rtr      (rx_rtr),
    .rx_dlc      (rx_dlc),
    .rx_data     (rx_data),
    .err_stuff   (err_stuff),
    .err_crc     (err_crc),
    .err_form    (err_form),
    .overrun     (overrun)
  );

  always #5 baud_clk = ~baud_clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic logic [63:0] misc_outs();
    return 64'({busy, frame_done, frame_ok, rx_id, rx_ide, rx_rtr, rx_dlc,
                err_stuff, err_crc, err_form, overrun});
  endfunction

  // Remainder of M(x)*x^15 divided by the generator, by mod-2 long division.
  function automatic logic [14:0] crc15_div(input bit m[$]);
    bit          w[$];
    logic [15:0] gen;
    logic [14:0] r;
    gen = {1'b1, CRC_POLY};
    w = m;
    for (int i = 0; i < 15; i++) w.push_back(1'b0);
    for (int i = 0; i < m.size(); i++)
      if (w[i]) for (int j = 0; j <= 15; j++) w[i+j] ^= gen[15-j];
    for (int j = 0; j < 15; j++) r[14-j] = w[m.size()+j];
    return r;
  endfunction

  task automatic encode(input frm_t f, output logic [FRAME_W-1:0] raw, output int r_len,
                        output logic [63:0] exp_data);
    bit          u[$];
    bit          s[$];
    bit          last;
    int          n, run;
    logic [14:0] crc;
    u.push_back(1'b0);
    if (f.ext) begin
      for (int i = 28; i >= 18; i--) u.push_back(f.id[i]);
      u.push_back(1'b1); u.push_back(1'b1);
      for (int i = 17; i >= 0; i--) u.push_back(f.id[i]);
      u.push_back(f.rtr); u.push_back(1'b0); u.push_back(1'b0);
    end else begin
      for (int i = 10; i >= 0; i--) u.push_back(f.id[i]);
      u.push_back(f.rtr); u.push_back(1'b0); u.push_back(1'b0);
    end
    for (int i = 3; i >= 0; i--) u.push_back(f.dlc[i]);
    n = f.rtr ? 0 : ((int'(f.dlc) > 8) ? 8 : int'(f.dlc));
    exp_data = '0;
    for (int i = 0; i < 8 * n; i++) begin
      u.push_back(f.data[63-i]);
      exp_data[63-i] = f.data[63-i];
    end
    crc = crc15_div(u) ^ f.crc_xor;
    for (int i = 14; i >= 0; i--) u.push_back(crc[i]);
    run = 0; last = 1'b0;
    foreach (u[i]) begin
      s.push_back(u[i]);
      if (run != 0 && u[i] == last) run++;
      else begin run = 1; last = u[i]; end
      if (run == int'(STUFF_LEN) && i != u.size() - 1) begin
        s.push_back(~last);
        last = ~last;
        run  = 1;
      end
    end
    s.push_back(1'b1);
    r_len = s.size();
    raw = '1;
    foreach (s[i]) raw[FRAME_W-1-i] = s[i];
  endtask

  // Launch a frame, optionally pulse finished_rx again ovr_at cycles in, wait for frame_done.
  task automatic run_frame(input logic [FRAME_W-1:0] raw, input int r_len, input int ovr_at);
    int c;
    bit got;
    @(negedge baud_clk); shifted_bus = raw; finished_rx = 1'b1;
    @(posedge baud_clk); #1;
    check_eq("busy_rise", 64'(busy), 64'd1);
    c = 0; got = 1'b0;
    while (!got && c < 400) begin
      @(negedge baud_clk); finished_rx = (ovr_at > 0 && c == ovr_at);
      @(posedge baud_clk); #1;
      c++;
      if (frame_done) got = 1'b1;
    end
    check_eq("done_seen", 64'(got), 64'd1);
    if (r_len > 0) check_eq("latency", 64'(c), 64'(r_len));
  endtask

  task automatic check_after();
    @(posedge baud_clk); #1;
    check_eq("done_pulse", 64'(frame_done), 64'd0);
    check_eq("busy_fall", 64'(busy), 64'd0);
  endtask

  task automatic good_frame(input frm_t f, input int ovr_at);
    logic [FRAME_W-1:0] raw;
    logic [63:0]        d;
    int                 r;
    logic               ec;
    encode(f, raw, r, d);
    run_frame(raw, r, ovr_at);
    ec = (f.crc_xor != '0);
    check_eq("rx_id", 64'(rx_id), 64'(f.id));
    check_eq("rx_ide", 64'(rx_ide), 64'(f.ext));
    check_eq("rx_rtr", 64'(rx_rtr), 64'(f.rtr));
    check_eq("rx_dlc", 64'(rx_dlc), 64'(f.dlc));
    check_eq("rx_data", rx_data, d);
    check_eq("err_stuff", 64'(err_stuff), 64'd0);
    check_eq("err_crc", 64'(err_crc), 64'(ec));
    check_eq("err_form", 64'(err_form), 64'd0);
    check_eq("frame_ok", 64'(frame_ok), 64'(!ec));
    check_eq("overrun", 64'(overrun), 64'(ovr_at > 0));
    check_after();
  endtask

  initial begin
    frm_t               f;
    logic [FRAME_W-1:0] raw;
    logic [63:0]        d;
    int                 r;
    bit                 got;

    rst = 1'b0; finished_rx = 1'b0; shifted_bus = '1;
    repeat (3) @(negedge baud_clk);
    check_eq("rst_outs", misc_outs(), 64'd0);
    check_eq("rst_data", rx_data, 64'd0);
    rst = 1'b1;
    repeat (2) @(negedge baud_clk);

    f = '{id: 29'h123, ext: 1'b0, rtr: 1'b0, dlc: 4'd1, data: 64'hA5FF_FFFF_FFFF_FFFF, crc_xor: 15'd0};
    good_frame(f, 0);
    f = '{id: 29'h0, ext: 1'b0, rtr: 1'b0, dlc: 4'd0, data: 64'hFFFF_FFFF_FFFF_FFFF, crc_xor: 15'd0};
    good_frame(f, 0);

    // Same all-zero frame with its first stuff bit inverted.
    encode(f, raw, r, d);
    raw[FRAME_W-1-5] = ~raw[FRAME_W-1-5];
    run_frame(raw, -1, 0);
    check_eq("stuff_err", 64'(err_stuff), 64'd1);
    check_eq("stuff_ok", 64'(frame_ok), 64'd0);
    check_after();

    f = '{id: 29'h5A5, ext: 1'b0, rtr: 1'b0, dlc: 4'd15, data: {$urandom, $urandom}, crc_xor: 15'd0};
    good_frame(f, 0);
    f = '{id: 29'h2F0, ext: 1'b0, rtr: 1'b1, dlc: 4'd4, data: {$urandom, $urandom}, crc_xor: 15'd0};
    good_frame(f, 0);

    f = '{id: 29'h3C7, ext: 1'b0, rtr: 1'b0, dlc: 4'd3, data: {$urandom, $urandom},
          crc_xor: 15'(1 << $urandom_range(0, 14))};
    good_frame(f, 0);

    f = '{id: 29'h1ABCDEF0, ext: 1'b1, rtr: 1'b0, dlc: 4'd2, data: {$urandom, $urandom}, crc_xor: 15'd0};
`ifdef CAN_EXT_ID_EN
    good_frame(f, 0);
`else
    encode(f, raw, r, d);
    run_frame(raw, -1, 0);
    check_eq("ide_form", 64'(err_form), 64'd1);
    check_eq("ide_bit", 64'(rx_ide), 64'd1);
    check_eq("ide_ok", 64'(frame_ok), 64'd0);
    check_eq("ide_id_hi", 64'(rx_id[28:11]), 64'd0);
    check_after();
`endif

    f = '{id: 29'h7FF, ext: 1'b0, rtr: 1'b0, dlc: 4'd8, data: {$urandom, $urandom}, crc_xor: 15'd0};
    good_frame(f, 20);

    for (int k = 0; k < 12; k++) begin
      f.id      = 29'($urandom_range(0, 2047));
      f.ext     = 1'b0;
      f.rtr     = ($urandom_range(0, 3) == 0);
      f.dlc     = 4'($urandom_range(0, 15));
      f.data    = {$urandom, $urandom};
      f.crc_xor = ($urandom_range(0, 4) == 0) ? 15'(1 << $urandom_range(0, 14)) : 15'd0;
      good_frame(f, 0);
    end

    // Reset in the middle of a frame: outputs clear, no frame_done follows.
    f = '{id: 29'h456, ext: 1'b0, rtr: 1'b0, dlc: 4'd4, data: {$urandom, $urandom}, crc_xor: 15'd0};
    encode(f, raw, r, d);
    @(negedge baud_clk); shifted_bus = raw; finished_rx = 1'b1;
    @(negedge baud_clk); finished_rx = 1'b0;
    repeat (10) @(negedge baud_clk);
    rst = 1'b0;
    #1;
    check_eq("midrst_outs", misc_outs(), 64'd0);
    check_eq("midrst_data", rx_data, 64'd0);
    @(negedge baud_clk); rst = 1'b1;
    got = 1'b0;
    repeat (r + 10) begin
      @(posedge baud_clk); #1;
      if (frame_done || busy) got = 1'b1;
    end
    check_eq("midrst_quiet", 64'(got), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
